// File: rtl/sobel_mode_ctrl.sv
// ============================================================================
// Module   : sobel_mode_ctrl
// Brief    : Frame-synchronous filter/test-pattern mode controller driving
//            OV7670 register writes through a req/ack configuration port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sobel_mode_ctrl #(
  parameter int                c_to_w       = 16,
  parameter logic [c_to_w-1:0] c_timeout    = 16'd50000,
  parameter logic [7:0]        c_addr_a     = 8'h70,
  parameter logic [7:0]        c_data_a     = 8'h3A,
  parameter logic [7:0]        c_addr_b     = 8'h71,
  parameter logic [7:0]        c_data_b_off = 8'h35,
  parameter logic [7:0]        c_data_b_on  = 8'hB5
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       filter_on_req,
  input  logic       vfilter_req,
  input  logic       test_mode_req,
  input  logic       vsync,
  output logic       cfg_req,
  output logic [7:0] cfg_addr,
  output logic [7:0] cfg_data,
  input  logic       cfg_ack,
  output logic       filter_on,
  output logic       vfilter,
  output logic       test_mode,
  output logic       busy,
  output logic       cfg_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WR_A   = 3'd1;
  localparam logic [2:0] S_GAP    = 3'd2;
  localparam logic [2:0] S_WR_B   = 3'd3;
  localparam logic [2:0] S_SETTLE = 3'd4;

  localparam logic [c_to_w-1:0] c_to_last = c_timeout - c_to_w'(1);

  logic [2:0]        r_state;
  logic              r_target;
  logic              r_vsync_d;
  logic [c_to_w-1:0] r_to_cnt;

  logic w_vsync_rise;
  logic w_in_wr;
  logic w_to_hit;

  assign w_vsync_rise = vsync & ~r_vsync_d;
  assign w_in_wr      = (r_state == S_WR_A) || (r_state == S_WR_B);
  // An ack in the final timeout cycle still completes the write.
  assign w_to_hit     = w_in_wr && !cfg_ack && (r_to_cnt == c_to_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_target  <= 1'b0;
      r_vsync_d <= 1'b0;
      r_to_cnt  <= '0;
      filter_on <= 1'b0;
      vfilter   <= 1'b0;
      test_mode <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      r_vsync_d <= vsync;
      if (w_vsync_rise) begin
        filter_on <= filter_on_req;
        vfilter   <= vfilter_req;
      end
      // Held at zero outside the write states, so every write starts from 0.
      r_to_cnt <= w_in_wr ? r_to_cnt + c_to_w'(1) : '0;

      case (r_state)
        S_IDLE: begin
          if (test_mode_req != test_mode) begin
            r_target <= test_mode_req;
            r_state  <= S_WR_A;
          end
        end
        S_WR_A: begin
          if (cfg_ack) begin
            r_state <= S_GAP;
          end else if (w_to_hit) begin
            cfg_err <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        S_GAP: r_state <= S_WR_B;
        S_WR_B: begin
          if (cfg_ack) begin
            r_state <= S_SETTLE;
          end else if (w_to_hit) begin
            cfg_err <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        S_SETTLE: begin
          if (w_vsync_rise) begin
            test_mode <= r_target;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Port outputs decode straight from state so reset clears them at once.
  always_comb begin
    cfg_req  = w_in_wr;
    cfg_addr = 8'h00;
    cfg_data = 8'h00;
    if (r_state == S_WR_A) begin
      cfg_addr = c_addr_a;
      cfg_data = c_data_a;
    end else if (r_state == S_WR_B) begin
      cfg_addr = c_addr_b;
      cfg_data = r_target ? c_data_b_on : c_data_b_off;
    end
  end

  assign busy = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_sobel_mode_ctrl.sv
// ============================================================================
// Module   : tb_sobel_mode_ctrl
// Brief    : Self-checking bench for sobel_mode_ctrl with a cycle model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sobel_mode_ctrl;

  localparam int TIMEOUT = 16;

  logic       rst, clk;
  logic       filter_on_req, vfilter_req, test_mode_req, vsync;
  logic       cfg_req, cfg_ack;
  logic [7:0] cfg_addr, cfg_data;
  logic       filter_on, vfilter, test_mode, busy, cfg_err;
  logic       ack_en;

  int n_checks = 0;
  int n_err    = 0;

  sobel_mode_ctrl #(.c_to_w(16), .c_timeout(16'(TIMEOUT))) u_dut (
    .rst(rst), .clk(clk),
    .filter_on_req(filter_on_req), .vfilter_req(vfilter_req),
    .test_mode_req(test_mode_req), .vsync(vsync),
    .cfg_req(cfg_req), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_ack(cfg_ack),
    .filter_on(filter_on), .vfilter(vfilter), .test_mode(test_mode),
    .busy(busy), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sequence progress 0 none, 1 first write, 2 gap,
  // 3 second write, 4 waiting for the next frame start.
  int         m_phase, m_cycles;
  logic       m_target, m_vs_d, m_fon, m_vf, m_tm, m_err;
  logic [7:0] wr_addr [2];
  assign wr_addr[0] = 8'h70;
  assign wr_addr[1] = 8'h71;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0; m_cycles <= 0; m_target <= 1'b0; m_vs_d <= 1'b0;
      m_fon <= 1'b0; m_vf <= 1'b0; m_tm <= 1'b0; m_err <= 1'b0;
    end else begin
      m_vs_d <= vsync;
      if (vsync && !m_vs_d) begin
        m_fon <= filter_on_req;
        m_vf  <= vfilter_req;
      end
      case (m_phase)
        0: if (test_mode_req != m_tm) begin
             m_target <= test_mode_req; m_phase <= 1; m_cycles <= 0;
           end
        1, 3: if (cfg_ack) m_phase <= m_phase + 1;
              else if (m_cycles == TIMEOUT - 1) begin m_err <= 1'b1; m_phase <= 0; end
              else m_cycles <= m_cycles + 1;
        2: begin m_phase <= 3; m_cycles <= 0; end
        default: if (vsync && !m_vs_d) begin m_tm <= m_target; m_phase <= 0; end
      endcase
    end
  end

  always @(posedge clk) begin
    logic       e_req;
    logic [7:0] e_addr, e_data;
    #1;
    e_req  = (m_phase == 1) || (m_phase == 3);
    e_addr = e_req ? wr_addr[(m_phase - 1) / 2] : 8'h00;
    e_data = (m_phase == 1) ? 8'h3A : (m_phase == 3) ? (m_target ? 8'hB5 : 8'h35) : 8'h00;
    check("cyc_cfg_req",   cfg_req,   e_req);
    check("cyc_cfg_addr",  cfg_addr,  e_addr);
    check("cyc_cfg_data",  cfg_data,  e_data);
    check("cyc_busy",      busy,      m_phase != 0);
    check("cyc_filter_on", filter_on, m_fon);
    check("cyc_vfilter",   vfilter,   m_vf);
    check("cyc_test_mode", test_mode, m_tm);
    check("cyc_cfg_err",   cfg_err,   m_err);
  end

  // SCCB stand-in: acks on the third cycle of each request when enabled.
  initial begin
    int cnt;
    cnt = 0;
    cfg_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (cfg_req && ack_en) begin
        cnt++;
        cfg_ack = (cnt == 3);
      end else begin
        cnt = 0;
        cfg_ack = 1'b0;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_write(input logic [7:0] addr, input string name);
    int n;
    n = 0;
    while (!(cfg_req && cfg_addr == addr) && n < 200) begin
      @(negedge clk); n++;
    end
    check(name, {7'b0, cfg_req && cfg_addr == addr}, 8'h01);
  endtask

  task automatic wait_low(input string name);
    int n;
    n = 0;
    while (cfg_req && n < 200) begin
      @(negedge clk); n++;
    end
    check(name, {7'b0, cfg_req}, 8'h00);
  endtask

  task automatic frame_start();
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
  endtask

  initial begin
    int g;
    rst = 1'b1; filter_on_req = 1'b0; vfilter_req = 1'b0;
    test_mode_req = 1'b0; vsync = 1'b0; ack_en = 1'b0;
    cycles(2);
    check("rst_cfg_req", cfg_req, 8'h00);
    check("rst_cfg_addr", cfg_addr, 8'h00);
    check("rst_outputs", {3'b0, filter_on, vfilter, test_mode, busy, cfg_err}, 8'h00);
    rst = 1'b0;

    // Idle frames with all requests low.
    repeat (3) begin frame_start(); cycles(5); end
    check("idle_outputs", {cfg_req, filter_on, vfilter, test_mode, busy, cfg_err}, 8'h00);

    // Filter request mid-frame waits for the next frame start.
    filter_on_req = 1'b1; vfilter_req = 1'b1;
    cycles(3);
    check("filter_hold", {filter_on, vfilter}, 8'h00);
    vsync = 1'b1;
    #1 check("filter_same_cycle", {filter_on, vfilter}, 8'h00);
    @(negedge clk);
    check("filter_applied", {filter_on, vfilter}, 8'h03);
    vsync = 1'b0;
    cycles(2);

    // Switch test pattern on.
    ack_en = 1'b1;
    test_mode_req = 1'b1;
    wait_write(8'h70, "on_wr_a");
    check("on_wr_a_data", cfg_data, 8'h3A);
    wait_low("on_wr_a_end");
    g = 0;
    while (!cfg_req && g < 50) begin g++; @(negedge clk); end
    check("on_gap_len", g[7:0], 8'd1);
    check("on_wr_b_addr", cfg_addr, 8'h71);
    check("on_wr_b_data", cfg_data, 8'hB5);
    wait_low("on_wr_b_end");
    cycles(3);
    check("on_settle", {busy, test_mode}, 8'h02);
    frame_start();
    check("on_applied", {busy, test_mode}, 8'h01);
    cycles(2);

    // Back to normal image, with the request flipped during the second write.
    test_mode_req = 1'b0;
    wait_write(8'h71, "off_wr_b");
    check("off_wr_b_data", cfg_data, 8'h35);
    test_mode_req = 1'b1;
    wait_low("off_wr_b_end");
    cycles(2);
    frame_start();
    check("off_applied", {busy, test_mode}, 8'h00);
    wait_write(8'h70, "re_wr_a");
    wait_write(8'h71, "re_wr_b");
    check("re_wr_b_data", cfg_data, 8'hB5);
    wait_low("re_wr_b_end");
    frame_start();
    check("re_applied", test_mode, 8'h01);
    cycles(2);

    // Timeout: nobody acks.
    ack_en = 1'b0;
    test_mode_req = 1'b0;
    wait_write(8'h70, "to_wr_a");
    g = 0;
    while (cfg_req && g < 100) begin g++; @(negedge clk); end
    check("to_req_len", g[7:0], 8'd16);
    check("to_err", {cfg_err, test_mode, busy}, 8'h06);
    @(negedge clk);
    check("to_retry", {cfg_req, cfg_err}, 8'h03);
    cycles(2);

    // Asynchronous reset mid-write.
    test_mode_req = 1'b0;
    rst = 1'b1;
    #1;
    check("arst_cfg_req", cfg_req, 8'h00);
    check("arst_outputs", {3'b0, filter_on, vfilter, test_mode, busy, cfg_err}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    filter_on_req = 1'b0; vfilter_req = 1'b0;
    cycles(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire
